// File: rtl/rgb2hsv_pkg.sv
// Shared constants for the RGB to HSV converter: FSM encodings, fixed-point
// unity, the 360-degree wrap threshold and the divider iteration count.
package rgb2hsv_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_MINMAX = 3'd1;
  localparam logic [2:0] ST_DIV_S  = 3'd2;
  localparam logic [2:0] ST_DIV_H  = 3'd3;
  localparam logic [2:0] ST_SCALE  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic [17:0] ONE      = 18'h10000;
  localparam logic [24:0] FULL_360 = 25'h1680000;
  localparam int          DIV_ITER = 17;

  typedef enum logic [1:0] {SRC_R, SRC_G, SRC_B} src_t;

endpackage

// File: rtl/seq_div_u17.sv
// Restoring divider: floor(num * 2^16 / den), one quotient bit per cycle, MSB first.
// The start edge resolves the first bit; done rises after the last of DIV_ITER steps.
module seq_div_u17
  import rgb2hsv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  num,
  input  logic [9:0]  den,
  output logic [16:0] quo,
  output logic        done
);

  logic [9:0]  rem;
  logic [9:0]  den_q;
  logic [4:0]  cnt;
  logic        busy;
  logic [10:0] trial;
  logic [10:0] diff;
  logic [9:0]  dsel;
  logic        qbit;
  logic [9:0]  rem_nxt;

  // Callers guarantee num <= den, so only the low dividend bits ever need
  // shifting in; after the first step they are all the zero fraction bits.
  always_comb begin
    trial   = start ? {1'b0, num} : {rem, 1'b0};
    dsel    = start ? den : den_q;
    diff    = trial - {1'b0, dsel};
    qbit    = (trial >= {1'b0, dsel});
    rem_nxt = qbit ? diff[9:0] : trial[9:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem   <= '0;
      den_q <= '0;
      quo   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (start) begin
      rem   <= rem_nxt;
      den_q <= den;
      quo   <= {16'b0, qbit};
      cnt   <= 5'(DIV_ITER - 1);
      busy  <= 1'b1;
      done  <= 1'b0;
    end else if (busy) begin
      rem <= rem_nxt;
      quo <= {quo[15:0], qbit};
      cnt <= cnt - 5'd1;
      if (cnt == 5'd1) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/rgb2hsv.sv
// Converts one 10-bit RGB sample to fixed-point HSV with a fixed 36-cycle latency;
// not pipelined: IN_READY is high only when idle, results wait for OUT_READY.
module rgb2hsv
  import rgb2hsv_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [9:0]  R,
  input  logic [9:0]  G,
  input  logic [9:0]  B,
  input  logic        IN_VALID,
  output logic        IN_READY,
  output logic [24:0] H,
  output logic [17:0] S,
  output logic [17:0] V,
  output logic        OUT_VALID,
  input  logic        OUT_READY
);

  logic [2:0]  state;
  logic [9:0]  r_q, g_q, b_q;
  logic [9:0]  mx_q, delta_q;
  src_t        src_q;
  logic [16:0] s_q;
  logic [24:0] hp_q;

  src_t        src;
  logic [9:0]  mx, mn, dl;
  logic [9:0]  opa, opb, absn;
  logic        pos;
  logic [24:0] base_pos, base_neg, f, hp, h60;

  logic        div_start, div_done;
  logic [9:0]  div_num, div_den;
  logic [16:0] div_quo;

  assign IN_READY = (state == ST_IDLE);

  always_comb begin
    src = SRC_R;
    mx  = r_q;
    if (r_q >= g_q && r_q >= b_q) begin
      src = SRC_R;
      mx  = r_q;
    end else if (g_q >= b_q) begin
      src = SRC_G;
      mx  = g_q;
    end else begin
      src = SRC_B;
      mx  = b_q;
    end
    mn = r_q;
    if (g_q < mn) mn = g_q;
    if (b_q < mn) mn = b_q;
    dl = mx - mn;
  end

  // Hue sector operands; the red sector wraps negative offsets around 6.
  always_comb begin
    opa      = g_q;
    opb      = b_q;
    base_pos = '0;
    base_neg = 25'(ONE) * 25'd6;
    case (src_q)
      SRC_G: begin
        opa      = b_q;
        opb      = r_q;
        base_pos = 25'(ONE) << 1;
        base_neg = 25'(ONE) << 1;
      end
      SRC_B: begin
        opa      = r_q;
        opb      = g_q;
        base_pos = 25'(ONE) << 2;
        base_neg = 25'(ONE) << 2;
      end
      default: ;
    endcase
    pos  = (opa >= opb);
    absn = pos ? (opa - opb) : (opb - opa);
    f    = {8'b0, div_quo};
    hp   = pos ? (base_pos + f) : (base_neg - f);
    h60  = (hp_q << 6) - (hp_q << 2);
  end

  assign div_start = (state == ST_MINMAX) || (state == ST_DIV_S && div_done);
  assign div_num   = (state == ST_MINMAX) ? dl : absn;
  assign div_den   = (state == ST_MINMAX) ? mx : delta_q;

  seq_div_u17 u_div (
    .clk   (CLK),
    .rst   (RST),
    .start (div_start),
    .num   (div_num),
    .den   (div_den),
    .quo   (div_quo),
    .done  (div_done)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      mx_q      <= '0;
      delta_q   <= '0;
      src_q     <= SRC_R;
      s_q       <= '0;
      hp_q      <= '0;
      H         <= '0;
      S         <= '0;
      V         <= '0;
      OUT_VALID <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (IN_VALID) begin
            r_q   <= R;
            g_q   <= G;
            b_q   <= B;
            state <= ST_MINMAX;
          end
        end
        ST_MINMAX: begin
          mx_q    <= mx;
          delta_q <= dl;
          src_q   <= src;
          state   <= ST_DIV_S;
        end
        ST_DIV_S: begin
          if (div_done) begin
            s_q   <= div_quo;
            state <= ST_DIV_H;
          end
        end
        ST_DIV_H: begin
          if (div_done) begin
            hp_q  <= hp;
            state <= ST_SCALE;
          end
        end
        ST_SCALE: begin
          // Black and gray leave the divider with a zero divisor; its result is discarded.
          H         <= (delta_q == 10'd0 || h60 >= FULL_360) ? 25'd0 : h60;
          S         <= (mx_q == 10'd0) ? 18'd0 : {1'b0, s_q};
          V         <= {2'b0, mx_q, 6'b0};
          OUT_VALID <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
